// File: rtl/order_entry_interface_if.sv
// order_entry_interface_if
//   Groups the order-side valid/ready handshake and the framed transmit beat
//   stream of the order entry framer.
//   slave  : the framer (accepts orders, drives tx beats)
//   master : strategy logic plus link (drives orders and tx_ready)
//   order_data/order_valid/order_ready : 64-bit order word handshake
//   tx_data/tx_valid/tx_ready          : 16-bit beat handshake
//   tx_sof/tx_eof                      : header / checksum beat markers
//   tx_seq                             : sequence number of current/next frame
interface order_entry_interface_if;
    logic [63:0] order_data;
    logic        order_valid;
    logic        order_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sof;
    logic        tx_eof;
    logic [7:0]  tx_seq;

    modport slave (
        input  order_data, order_valid, tx_ready,
        output order_ready, tx_data, tx_valid, tx_sof, tx_eof, tx_seq
    );

    modport master (
        output order_data, order_valid, tx_ready,
        input  order_ready, tx_data, tx_valid, tx_sof, tx_eof, tx_seq
    );
endinterface

// File: rtl/order_entry_interface.sv
// order_entry_interface
//   Buffers 64-bit order words in a small FIFO and emits each one as a
//   6-beat 16-bit frame: header {SYNC_BYTE, seq}, four payload beats
//   (MSB beat first) and an XOR checksum of the five preceding beats.
//   clk     : single clock, posedge
//   reset_n : asynchronous active-low reset; discards FIFO and in-flight frame
//   bus     : order_entry_interface_if.slave (order handshake + tx beat stream)
module order_entry_interface #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    order_entry_interface_if.slave  bus
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_e;

    // ---------------- order FIFO ----------------
    logic [63:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          order_ready_q, order_ready_d;
    logic          nempty_q, nempty_d;
    logic          push, pop, avail;

    // ---------------- framer ----------------
    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [63:0]   word_q, word_d;
    logic [15:0]   xor_q, xor_d;
    logic [7:0]    seq_q, seq_d;
    logic [15:0]   tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_sof_q, tx_sof_d;
    logic          tx_eof_q, tx_eof_d;
    logic          adv;
    logic [15:0]   nxt_beat, hdr_now, hdr_next;

    function automatic logic [15:0] pay_beat(input logic [63:0] w, input logic [1:0] i);
        logic [15:0] r;
        case (i)
            2'd0:    r = w[63:48];
            2'd1:    r = w[47:32];
            2'd2:    r = w[31:16];
            default: r = w[15:0];
        endcase
        return r;
    endfunction

    assign push = bus.order_valid && order_ready_q;
    // An entry becomes poppable only after it has been in the FIFO for a full
    // cycle (nempty_q lags count_q); this fixes the order-to-header latency at
    // two edges. count_q != 0 guards against the stale flag after a drain.
    assign avail = (count_q != '0) && nempty_q;
    assign adv   = tx_valid_q && bus.tx_ready;

    always_comb begin
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        count_d       = count_q + CW'(push) - CW'(pop);
        order_ready_d = (count_d != CW'(FIFO_DEPTH));
        nempty_d      = (count_q != '0);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.order_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            order_ready_q <= 1'b0;
            nempty_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            order_ready_q <= order_ready_d;
            nempty_q      <= nempty_d;
        end
    end

    // Outputs are registered: each transition loads the beat of the state
    // being entered, so tx_* always describe state_q.
    assign nxt_beat = pay_beat(word_q, (state_q == HDR) ? 2'd0 : idx_q + 2'd1);
    assign hdr_now  = {SYNC_BYTE, seq_q};
    assign hdr_next = {SYNC_BYTE, seq_q + 8'd1};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        xor_d      = xor_q;
        seq_d      = seq_q;
        pop        = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_sof_d   = tx_sof_q;
        tx_eof_d   = tx_eof_q;
        case (state_q)
            IDLE: begin
                if (avail) begin
                    pop        = 1'b1;
                    word_d     = fifo_mem[rd_ptr_q];
                    state_d    = HDR;
                    tx_data_d  = hdr_now;
                    tx_valid_d = 1'b1;
                    tx_sof_d   = 1'b1;
                    tx_eof_d   = 1'b0;
                    xor_d      = hdr_now;
                end
            end
            HDR: begin
                if (adv) begin
                    state_d   = PAY;
                    idx_d     = 2'd0;
                    tx_data_d = nxt_beat;
                    tx_sof_d  = 1'b0;
                    xor_d     = xor_q ^ nxt_beat;
                end
            end
            PAY: begin
                if (adv) begin
                    if (idx_q == 2'd3) begin
                        state_d   = CSUM;
                        tx_data_d = xor_q;
                        tx_eof_d  = 1'b1;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = nxt_beat;
                        xor_d     = xor_q ^ nxt_beat;
                    end
                end
            end
            CSUM: begin
                if (adv) begin
                    seq_d    = seq_q + 8'd1;
                    tx_eof_d = 1'b0;
                    if (avail) begin
                        // chain straight into the next header, no idle beat
                        pop       = 1'b1;
                        word_d    = fifo_mem[rd_ptr_q];
                        state_d   = HDR;
                        tx_data_d = hdr_next;
                        tx_sof_d  = 1'b1;
                        xor_d     = hdr_next;
                    end else begin
                        state_d    = IDLE;
                        tx_data_d  = 16'h0000;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            word_q     <= '0;
            xor_q      <= '0;
            seq_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_sof_q   <= 1'b0;
            tx_eof_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            xor_q      <= xor_d;
            seq_q      <= seq_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_sof_q   <= tx_sof_d;
            tx_eof_q   <= tx_eof_d;
        end
    end

    assign bus.order_ready = order_ready_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_sof      = tx_sof_q;
    assign bus.tx_eof      = tx_eof_q;
    assign bus.tx_seq      = seq_q;

endmodule
